// File: rtl/bus_pkg.sv
// Shared definitions for the bus slave RAM: FSM states, response codes and
// default bus widths.
package bus_pkg;

    // Default geometry of the slave as seen from the interconnect.
    localparam int unsigned AddrWDef   = 8;
    localparam int unsigned DataWDef   = 32;
    localparam int unsigned DepthDef   = 64;
    localparam int unsigned WaitCycDef = 2;

    // Response codes carried on the err line alongside ready.
    localparam logic RespOkay = 1'b0;
    localparam logic RespErr  = 1'b1;

    // Transaction FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // Wait-state counter width; a zero-wait build still keeps one bit.
    function automatic int unsigned cnt_width(input int unsigned wait_cyc);
        return (wait_cyc == 0) ? 1 : $clog2(wait_cyc + 1);
    endfunction

endpackage

// File: rtl/bus_ram_be.sv
// Byte-enabled synchronous word array with a registered read port.
// The read register clears to zero on any cycle without a read request, so the
// slave's rdata is zero everywhere except the single response cycle.
module bus_ram_be #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned IDX_W  = 6
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int unsigned BeW = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_q;

    // Storage is intentionally not reset; only enabled byte lanes are written.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            for (int i = 0; i < int'(BeW); i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Registered read port, zero outside a read access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q <= '0;
        end else if (req_i && !we_i) begin
            rd_q <= mem_q[idx_i];
        end else begin
            rd_q <= '0;
        end
    end

    assign rdata_o = rd_q;

endmodule

// File: rtl/bus_slave_ram.sv
// Memory-mapped RAM slave behind the bus_all interconnect.
// A request is captured in IDLE, held for WAIT_CYC wait states, and answered
// with a one-cycle ready strobe. The memory access happens on the edge that
// enters RESP, so a write abandoned by reset during WAIT never lands.
// Build option: define BUS_SLAVE_ERR_EN to flag addr >= DEPTH as an error
// (write dropped, read data zero); otherwise the address wraps modulo DEPTH.
module bus_slave_ram
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W   = AddrWDef,
    parameter int unsigned DATA_W   = DataWDef,
    parameter int unsigned DEPTH    = DepthDef,
    parameter int unsigned WAIT_CYC = WaitCycDef
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic [DATA_W-1:0]   rdata,
    output logic                err
);

    localparam int unsigned BeW  = DATA_W / 8;
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = cnt_width(WAIT_CYC);

    localparam logic [CntW-1:0] CntLoad = (WAIT_CYC > 0) ? CntW'(WAIT_CYC - 1) : '0;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BeW-1:0]    be_q;

    logic              capture;
    logic              access;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [BeW-1:0]    acc_be;
    logic [IdxW-1:0]   acc_idx;
    logic              acc_oor;
    logic              ram_req;

    // Next-state and wait counter; access marks the edge that enters RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        access  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sel) begin
                    capture = 1'b1;
                    if (WAIT_CYC == 0) begin
                        state_d = StResp;
                        access  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Holding registers for the captured request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (capture) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
        end
    end

    // Zero-wait accesses happen on the capture edge, so they use the live inputs.
    always_comb begin
        if (state_q == StIdle) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_be    = be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
    end

    assign acc_idx = acc_addr[IdxW-1:0];

`ifdef BUS_SLAVE_ERR_EN
    localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH);

    logic err_q;

    assign acc_oor = ({1'b0, acc_addr} >= DepthExt);

    // Error flag is loaded with the response and cleared the cycle after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= RespOkay;
        end else if (access && acc_oor) begin
            err_q <= RespErr;
        end else begin
            err_q <= RespOkay;
        end
    end

    assign err = err_q;
`else
    // Address wraps modulo DEPTH; bits above the index are don't-care.
    if (IdxW < ADDR_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^acc_addr[ADDR_W-1:IdxW];
    end

    assign acc_oor = 1'b0;
    assign err     = RespOkay;
`endif

    assign ram_req = access && !acc_oor;

    bus_ram_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IdxW)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (ram_req),
        .we_i    (acc_we),
        .idx_i   (acc_idx),
        .wdata_i (acc_wdata),
        .be_i    (acc_be),
        .rdata_o (rdata)
    );

    assign ready = (state_q == StResp);

endmodule
